// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU request arbiter.
package alu_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    localparam logic [SEL_W-1:0] OP_DIV = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // A divide with a zero divisor must never reach the ALU.
    function automatic logic is_div_zero(input logic [SEL_W-1:0] sel,
                                         input logic [DATA_W-1:0] b);
        return (sel == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: the most recently served requester
// loses a tie, a lone requester always wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant selection, zero when nobody requests.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters. One operation is in
// flight at a time; divides by zero are answered with an error without
// ever presenting them to the ALU.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [15:0]       req_a,
    input  logic [15:0]       req_b,
    input  logic [7:0]        req_sel,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry
);

    // EXEC lasts ALU_LATENCY cycles; the counter starts at ALU_LATENCY-1
    // and the capture happens when it reaches zero.
    localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          grant;
    logic                last_grant;
    logic                accept;
    logic                rsp_hs;
    logic                grant_idx_q;
    logic [DATA_W-1:0]   in_a;
    logic [DATA_W-1:0]   in_b;
    logic [SEL_W-1:0]    in_sel;
    logic                in_div_zero;
    logic [DATA_W-1:0]   lat_a;
    logic [DATA_W-1:0]   lat_b;
    logic [SEL_W-1:0]    lat_sel;
    logic [1:0]          cnt;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_carry_q;
    logic                rsp_err_q;

    rr_arbiter_2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Operands of whichever requester wins this cycle.
    always_comb begin
        in_a        = grant[1] ? req_a[15:8]  : req_a[7:0];
        in_b        = grant[1] ? req_b[15:8]  : req_b[7:0];
        in_sel      = grant[1] ? req_sel[7:4] : req_sel[3:0];
        in_div_zero = is_div_zero(in_sel, in_b);
        accept      = (state_q == IDLE) && (req_valid != 2'b00);
        rsp_hs      = (state_q == RESP) && rsp_ready[grant_idx_q];
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_div_zero ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 2'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, latency counter, response capture and priority pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_idx_q <= 1'b0;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_sel     <= '0;
            cnt         <= 2'd0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_idx_q <= grant[1];
                        lat_a       <= in_a;
                        lat_b       <= in_b;
                        lat_sel     <= in_sel;
                        cnt         <= CNT_INIT;
                        if (in_div_zero) begin
                            rsp_data_q  <= '0;
                            rsp_carry_q <= 1'b0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 2'd0) begin
                        rsp_data_q  <= alu_out;
                        rsp_carry_q <= alu_carry;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        last_grant <= grant_idx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; everything is forced low during reset.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        rsp_data  = '0;
        rsp_carry = 1'b0;
        rsp_err   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = '0;
        if (!reset) begin
            case (state_q)
                IDLE: req_ready = grant;
                EXEC: begin
                    alu_a   = lat_a;
                    alu_b   = lat_b;
                    alu_sel = lat_sel;
                end
                RESP: begin
                    rsp_valid = grant_idx_q ? 2'b10 : 2'b01;
                    rsp_data  = rsp_data_q;
                    rsp_carry = rsp_carry_q;
                    rsp_err   = rsp_err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LATENCY, default 1, means the cycles the ALU operands are held before the result is captured; legal range 1..4.
REQ-002 clock  input  1  single clock for all state; all flops on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  bit n: requester n presents an operation.
REQ-005 req_ready  output  2  bit n: requester n's operation accepted this cycle.
REQ-006 req_a  input  16  operand A; requester n on bits [8n+7:8n].
REQ-007 req_b  input  16  operand B; same packing as req_a.
REQ-008 req_sel  input  8  ALU opcode; requester n on bits [4n+3:4n].
REQ-009 rsp_valid  output  2  bit n: response for requester n is available.
REQ-010 rsp_ready  input  2  bit n: requester n takes its response.
REQ-011 rsp_data  output  8  result byte.
REQ-012 rsp_carry  output  1  captured ALU carry.
REQ-013 rsp_err  output  1  operation rejected as divide-by-zero.
REQ-014 alu_a  output  8  ALU operand A.
REQ-015 alu_b  output  8  ALU operand B.
REQ-016 alu_sel  output  4  ALU opcode.
REQ-017 alu_out  input  8  ALU result.
REQ-018 alu_carry  input  1  ALU carry out.

Function
REQ-019 The FSM SHALL have the states IDLE, EXEC and RESP, with one operation in flight at most.
REQ-020 In IDLE, req_ready SHALL be one-hot or zero: it is asserted combinationally only for the arbitration winner among the set req_valid bits.
REQ-021 Arbitration SHALL be round-robin over the 2 requesters: the requester granted most recently has low priority, and a lone valid requester always wins.
REQ-022 On req_valid[n]&req_ready[n], the block SHALL latch the grant index n and requester n's req_a, req_b and req_sel.
REQ-023 If the latched opcode equals OP_DIV (4'd3) and the latched B is 0, the block SHALL go directly to RESP with rsp_err=1, rsp_data=0 and rsp_carry=0, and SHALL NOT drive the ALU.
REQ-024 Otherwise the block SHALL go to EXEC.
REQ-025 In EXEC, alu_a, alu_b and alu_sel SHALL equal the latched operands for exactly ALU_LATENCY cycles, timed by a down-counter.
REQ-026 On the last EXEC cycle, the block SHALL register alu_out and alu_carry into rsp_data and rsp_carry, set rsp_err=0, and enter RESP.
REQ-027 Outside EXEC, alu_a, alu_b and alu_sel SHALL be 0, so alu_sel==OP_DIV implies alu_b!=0 on every cycle.
REQ-028 In RESP, rsp_valid[granted] SHALL be held high with rsp_data, rsp_carry and rsp_err stable until rsp_ready[granted].
REQ-029 When that handshake completes, the block SHALL return to IDLE and update the priority pointer.
REQ-030 rsp_ready on the non-granted bit SHALL be ignored.
REQ-031 Minimum accept-to-rsp_valid latency SHALL be ALU_LATENCY+1 cycles, or 1 cycle for a rejected divide.
REQ-032 A new request SHALL be accepted no earlier than the cycle after the response handshake; requests arriving meanwhile wait with req_ready=0.

Reset
REQ-033 While reset is high, the block SHALL be in IDLE and all outputs SHALL be 0, including in the same cycle reset asserts mid-EXEC or mid-RESP.
REQ-034 Reset SHALL set the priority pointer so that requester 0 wins a simultaneous request.
REQ-035 Reset SHALL discard any in-flight operation, with no response produced for it.

Structure
REQ-036 Package alu_ctrl_pkg SHALL hold the state enum, OP_DIV=4'd3, DATA_W=8 and SEL_W=4.
REQ-037 Arbitration SHALL be a separate sub-module rr_arbiter_2, with inputs req[1:0] and the pointer, and a one-hot grant output.

Verification
REQ-038 Scenario: req_valid=01, A=8'h0F, B=8'h01, sel=4'd0 (add), ALU_LATENCY=1 -> rsp_valid=01 two cycles after accept with rsp_data=8'h10, rsp_err=0.
REQ-039 Scenario: req_valid=11 held continuously after reset -> grants alternate 0,1,0,1, with rsp_valid matching each grant.
REQ-040 Scenario: requester 1 sends sel=4'd3, B=0 -> rsp_valid=10 one cycle after accept with rsp_err=1 and rsp_data=0, and alu_sel stays 0 throughout.
REQ-041 Scenario: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stay stable, and req_ready stays 00.
REQ-042 Scenario: reset pulsed during EXEC with ALU_LATENCY=4 -> all outputs are 0 immediately, no response appears, and the next simultaneous request grants requester 0.
REQ-043 Scenario: A=8'hFF, B=8'h01, add -> rsp_data=8'h00 and rsp_carry=1, with the divide-safety assertion bound on alu_* never failing.
